mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle main controller for the MIPS datapath: it replaces the single-cycle opcode decoder with a Moore/Mealy FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It sits between the instruction register and the datapath. It drives the mux selects with the existing encodings, plus per-state write enables and a request/ready memory handshake. Optional ISA extension, illegal-opcode handling and a retired-instruction counter are parameter-selected.

## Interface
- EXT_EN, 0: 1 decodes and/or/slt (funct 100100/100101/101010) and j (opcode 000010); 0 treats them as illegal.
- ILLEGAL_HALT, 0: 1 sends an illegal instruction to HALT; 0 retires it as nop.
- PERF_W, 32: width of `instret`.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- opcode  in  6  IR[31:26], stable from DECODE onward.
- funct  in  6  IR[5:0].
- Zero  in  1  ALU equality flag, valid in EXEC.
- mem_ready  in  1  memory completes the current request this cycle.
- NPCOp  out  2  00 PC+4, 01 branch, 10 imm26 jump, 11 register jump.
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 lui, 100 and, 101 slt.
- A3WRSel  out  2  00 rt, 01 rd, 10 $31.
- WDSel  out  2  00 ALU, 01 DM, 10 PC+4.
- EXTOp  out  1  1 = sign-extend (lw/sw), 0 = zero-extend.
- ALUBSel  out  1  1 = immediate operand (ori/lw/sw/lui).
- PCWr, IRWr, RFWE, DMWr  out  1 each  state-qualified write enables.
- mem_req  out  1  memory request.
- state  out  3  current state, for debug.
- illegal  out  1  one-cycle pulse in DECODE for an undecoded instruction.
- halted  out  1  high in HALT.
- instret  out  PERF_W  count of retired instructions.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Selects (ALUOp, ALUBSel, EXTOp, A3WRSel, WDSel) are pure decode of opcode/funct. They are valid from DECODE onward.
- NPCOp is 01 only for beq with Zero=1. Otherwise it is 10 for jal/j, 11 for jr, and 00 for everything else.
- Enables are 0 in every state except where listed below.
- FETCH:
  - mem_req=1.
  - On mem_ready=1: IRWr=1, next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - jal: RFWE=1 (A3=10, WD=10), PCWr=1 → FETCH.
  - j, jr: PCWr=1 → FETCH.
  - nop (opcode 0, funct 0): PCWr=1 → FETCH.
  - illegal: illegal=1. If ILLEGAL_HALT, go to HALT with no PCWr. Otherwise PCWr=1 → FETCH.
  - All other instructions → EXEC.
- EXEC:
  - beq: PCWr=1 → FETCH.
  - lw, sw → MEM.
  - add, sub, ori, lui, and, or, slt → WB.
- MEM:
  - mem_req=1; DMWr=1 for sw.
  - On mem_ready=1: lw → WB; sw asserts PCWr=1 → FETCH.
  - Otherwise stay in MEM.
- WB: RFWE=1 and PCWr=1 → FETCH.
- HALT: absorbing; no enables; left only through reset.
- Retirement is any cycle with PCWr=1. `instret` increments by 1 on each retirement and wraps modulo 2^PERF_W.

## Timing
- Reset (asynchronous):
  - state=FETCH, instret=0, halted=0.
  - While reset is high, every enable and mem_req is forced to 0.
  - On the first edge after release, FETCH issues mem_req.
- Memory handshake:
  - mem_req stays high and address/data hold until the edge that samples mem_ready=1.
  - mem_ready with mem_req=0 is ignored.
- Latency in cycles, with mem_ready tied high:
  - jal/j/jr/nop: 2.
  - beq: 3.
  - R-type, ori, lui, sw: 4.
  - lw: 5.
  - Each memory wait cycle adds 1 in FETCH or MEM.
- A reset asserted mid-instruction abandons it. No PCWr or RFWE is issued, and mem_req drops combinationally.
- Each instruction produces exactly one PCWr, except an instruction that halts, which produces none.

## Test plan
- Reset release with mem_ready=1, ori sequence → state trace 0,1,2,4,0; RFWE and PCWr high only in WB; ALUBSel=1, ALUOp=010; instret=1 after 4 cycles.
- lw with mem_ready low for 3 cycles in MEM → mem_req high 4 cycles in MEM; WB has WDSel=01 and RFWE=1; total 8 cycles.
- beq with Zero=1 and then Zero=0 → PCWr in EXEC with NPCOp=01 and then 00; 3 cycles each; RFWE never high.
- jal → DECODE asserts RFWE, A3WRSel=10, WDSel=10, PCWr, NPCOp=10 in one cycle; 2 cycles total.
- Opcode 000010 with EXT_EN=0, ILLEGAL_HALT=1 → illegal pulse, state=5, halted=1, instret frozen; reset returns to state 0, instret=0.
- PERF_W=4, 17 nops → instret=1 after wrap; reset asserted during MEM of sw → mem_req and DMWr drop immediately, and no PCWr is issued.

Source files
------------

// File: rtl/mc_control.sv
`default_nettype none
//==============================================================================
// mc_control: multi-cycle MIPS main controller (FETCH/DECODE/EXEC/MEM/WB/HALT)
// with memory request/ready handshake and retired-instruction counter.
// Revision: 1.0
//==============================================================================
module mc_control #(
  parameter bit          EXT_EN       = 1'b0,
  parameter bit          ILLEGAL_HALT = 1'b0,
  parameter int unsigned PERF_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              Zero,
  input  logic              mem_ready,
  output logic [1:0]        NPCOp,
  output logic [2:0]        ALUOp,
  output logic [1:0]        A3WRSel,
  output logic [1:0]        WDSel,
  output logic              EXTOp,
  output logic              ALUBSel,
  output logic              PCWr,
  output logic              IRWr,
  output logic              RFWE,
  output logic              DMWr,
  output logic              mem_req,
  output logic [2:0]        state,
  output logic              illegal,
  output logic              halted,
  output logic [PERF_W-1:0] instret
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_NOP = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [PERF_W-1:0] instret_q;

  logic is_r, i_nop, i_jr, i_add, i_sub, i_and, i_or, i_slt;
  logic i_j, i_jal, i_beq, i_ori, i_lui, i_lw, i_sw, i_alu_r, legal;

  assign is_r    = (opcode == OP_RTYPE);
  assign i_nop   = is_r && (funct == FN_NOP);
  assign i_jr    = is_r && (funct == FN_JR);
  assign i_add   = is_r && (funct == FN_ADD);
  assign i_sub   = is_r && (funct == FN_SUB);
  assign i_and   = is_r && (funct == FN_AND) && EXT_EN;
  assign i_or    = is_r && (funct == FN_OR)  && EXT_EN;
  assign i_slt   = is_r && (funct == FN_SLT) && EXT_EN;
  assign i_j     = (opcode == OP_J) && EXT_EN;
  assign i_jal   = (opcode == OP_JAL);
  assign i_beq   = (opcode == OP_BEQ);
  assign i_ori   = (opcode == OP_ORI);
  assign i_lui   = (opcode == OP_LUI);
  assign i_lw    = (opcode == OP_LW);
  assign i_sw    = (opcode == OP_SW);
  assign i_alu_r = i_add | i_sub | i_and | i_or | i_slt;
  assign legal   = i_alu_r | i_nop | i_jr | i_j | i_jal | i_beq | i_ori | i_lui | i_lw | i_sw;

  always_comb begin
    ALUOp = 3'b000;
    if (i_sub | i_beq)     ALUOp = 3'b001;
    else if (i_ori | i_or) ALUOp = 3'b010;
    else if (i_lui)        ALUOp = 3'b011;
    else if (i_and)        ALUOp = 3'b100;
    else if (i_slt)        ALUOp = 3'b101;
  end

  assign ALUBSel = i_ori | i_lw | i_sw | i_lui;
  assign EXTOp   = i_lw | i_sw;
  assign A3WRSel = i_jal ? 2'b10 : (is_r ? 2'b01 : 2'b00);
  assign WDSel   = i_lw ? 2'b01 : (i_jal ? 2'b10 : 2'b00);
  assign NPCOp   = (i_beq && Zero) ? 2'b01 :
                   (i_jal | i_j)   ? 2'b10 :
                   i_jr            ? 2'b11 : 2'b00;

  logic pc_wr, ir_wr, rf_we, dm_wr, req, ill;

  always_comb begin
    state_d = state_q;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    rf_we   = 1'b0;
    dm_wr   = 1'b0;
    req     = 1'b0;
    ill     = 1'b0;
    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          ill = 1'b1;
          if (ILLEGAL_HALT) begin
            state_d = S_HALT;
          end else begin
            pc_wr   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (i_jal) begin
          rf_we   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_FETCH;
        end else if (i_j | i_jr | i_nop) begin
          pc_wr   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (i_beq) begin
          pc_wr   = 1'b1;
          state_d = S_FETCH;
        end else if (i_lw | i_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        req   = 1'b1;
        dm_wr = i_sw;
        if (mem_ready) begin
          if (i_sw) begin
            pc_wr   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks strobes combinationally so an abandoned instruction never writes.
  assign PCWr    = pc_wr & ~reset;
  assign IRWr    = ir_wr & ~reset;
  assign RFWE    = rf_we & ~reset;
  assign DMWr    = dm_wr & ~reset;
  assign mem_req = req   & ~reset;
  assign illegal = ill   & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (pc_wr) instret_q <= instret_q + PERF_W'(1);
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for mc_control: expected retirements are queued by the
// stimulus and checked by a negedge monitor on every PCWr.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       Zero, mem_ready;

  logic [1:0] NPCOp, A3WRSel, WDSel;
  logic [2:0] ALUOp, state;
  logic       EXTOp, ALUBSel, PCWr, IRWr, RFWE, DMWr, mem_req, illegal, halted;
  logic [3:0] instret;

  logic [1:0] x_NPCOp, x_A3WRSel, x_WDSel;
  logic [2:0] x_ALUOp, x_state;
  logic       x_EXTOp, x_ALUBSel, x_PCWr, x_IRWr, x_RFWE, x_DMWr, x_mem_req, x_illegal, x_halted;
  logic [7:0] x_instret;

  mc_control #(.EXT_EN(1'b0), .ILLEGAL_HALT(1'b1), .PERF_W(4)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
    .mem_ready(mem_ready), .NPCOp(NPCOp), .ALUOp(ALUOp), .A3WRSel(A3WRSel),
    .WDSel(WDSel), .EXTOp(EXTOp), .ALUBSel(ALUBSel), .PCWr(PCWr), .IRWr(IRWr),
    .RFWE(RFWE), .DMWr(DMWr), .mem_req(mem_req), .state(state),
    .illegal(illegal), .halted(halted), .instret(instret));

  mc_control #(.EXT_EN(1'b1), .ILLEGAL_HALT(1'b0), .PERF_W(8)) u_ext (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
    .mem_ready(mem_ready), .NPCOp(x_NPCOp), .ALUOp(x_ALUOp), .A3WRSel(x_A3WRSel),
    .WDSel(x_WDSel), .EXTOp(x_EXTOp), .ALUBSel(x_ALUBSel), .PCWr(x_PCWr), .IRWr(x_IRWr),
    .RFWE(x_RFWE), .DMWr(x_DMWr), .mem_req(x_mem_req), .state(x_state),
    .illegal(x_illegal), .halted(x_halted), .instret(x_instret));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      lat;
    logic [7:0][2:0] trace;
    logic [1:0]      npc;
    logic [2:0]      alu;
    logic            bsel;
    logic            ext;
    logic [1:0]      a3;
    logic [1:0]      wd;
    logic            rfwe_ret;
    logic            dmwr_ret;
    logic [3:0]      rfwe_cnt;
    logic [3:0]      req_cnt;
    logic [3:0]      instret_pre;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   exp_ret = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts cycles and strobes per instruction, checks on retirement.
  int cnt = 0, rfwe_n = 0, req_n = 0, ir_n = 0;
  always @(negedge clk) begin
    if (reset) begin
      cnt = 0; rfwe_n = 0; req_n = 0; ir_n = 0;
    end else begin
      rfwe_n += int'(RFWE);
      req_n  += int'(mem_req);
      ir_n   += int'(IRWr);
      if (q.size() != 0 && cnt < 8) chk("state_trace", state, q[0].trace[cnt]);
      if (PCWr) begin
        chk("retire_pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("latency",   cnt + 1, q[0].lat);
          chk("NPCOp",     NPCOp,   q[0].npc);
          chk("ALUOp",     ALUOp,   q[0].alu);
          chk("ALUBSel",   ALUBSel, q[0].bsel);
          chk("EXTOp",     EXTOp,   q[0].ext);
          chk("A3WRSel",   A3WRSel, q[0].a3);
          chk("WDSel",     WDSel,   q[0].wd);
          chk("RFWE_ret",  RFWE,    q[0].rfwe_ret);
          chk("DMWr_ret",  DMWr,    q[0].dmwr_ret);
          chk("rfwe_cnt",  rfwe_n,  q[0].rfwe_cnt);
          chk("req_cnt",   req_n,   q[0].req_cnt);
          chk("irwr_cnt",  ir_n,    1);
          chk("instret",   instret, q[0].instret_pre);
          void'(q.pop_front());
        end
        cnt = 0; rfwe_n = 0; req_n = 0; ir_n = 0;
      end else begin
        cnt++;
      end
    end
  end

  // Queue the expected retirement, then drive the instruction cycle by cycle.
  // mem_ready is low for lo_n cycles starting at cycle lo_s.
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input string path, input logic [1:0] npc, input logic [2:0] alu,
                       input logic bsel, input logic ext, input logic [1:0] a3,
                       input logic [1:0] wd, input logic rfr, input logic dmr,
                       input int rfc, input int reqc, input int lo_s, input int lo_n);
    exp_t e;
    e = '0;
    e.lat = 4'(path.len());
    for (int i = 0; i < path.len(); i++) e.trace[i] = 3'(path[i] - 8'd48);
    e.npc = npc; e.alu = alu; e.bsel = bsel; e.ext = ext; e.a3 = a3; e.wd = wd;
    e.rfwe_ret = rfr; e.dmwr_ret = dmr;
    e.rfwe_cnt = 4'(rfc); e.req_cnt = 4'(reqc);
    e.instret_pre = 4'(exp_ret);
    exp_ret++;
    q.push_back(e);
    opcode = op; funct = fn; Zero = z;
    for (int k = 0; k < path.len(); k++) begin
      mem_ready = !(k >= lo_s && k < lo_s + lo_n);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
  endtask

  // Instruction observed only on the extension-enabled instance.
  task automatic ext_instr(input logic [5:0] op, input logic [5:0] fn, input int lat,
                           input logic [2:0] alu, input logic ill);
    opcode = op; funct = fn; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ext_ALUOp", x_ALUOp, alu);
    chk("ext_illegal", x_illegal, ill);
    for (int k = 2; k < lat; k++) @(negedge clk);
    chk("ext_PCWr", x_PCWr, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_PCWr", PCWr, 0);
    chk("rst_state", state, 0);
    @(posedge clk); #1;
    chk("rst_instret", instret, 0);
    chk("rst_halted", halted, 0);
    reset = 1'b0;
    exp_ret = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = 6'b001101; funct = 6'b0; Zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    do_reset();

    //     opcode     funct      Z  path        npc alu bs ex a3 wd rfr dmr rfc req lo_s lo_n
    instr(6'b001101, 6'b000000, 0, "0124",     0,  2,  1, 0, 0, 0, 1,  0,  1,  1,  0,   0); // ori
    chk("instret_after_ori", instret, 1);
    instr(6'b100011, 6'b000000, 0, "01233334", 0,  0,  1, 1, 0, 1, 1,  0,  1,  5,  3,   3); // lw
    instr(6'b000100, 6'b000000, 1, "012",      1,  1,  0, 0, 0, 0, 0,  0,  0,  1,  0,   0); // beq taken
    instr(6'b000100, 6'b000000, 0, "012",      0,  1,  0, 0, 0, 0, 0,  0,  0,  1,  0,   0); // beq not taken
    instr(6'b000011, 6'b000000, 0, "01",       2,  0,  0, 0, 2, 2, 1,  0,  1,  1,  0,   0); // jal
    instr(6'b000000, 6'b100000, 0, "000124",   0,  0,  0, 0, 1, 0, 1,  0,  1,  3,  0,   2); // add, fetch wait
    instr(6'b000000, 6'b100010, 0, "0124",     0,  1,  0, 0, 1, 0, 1,  0,  1,  1,  0,   0); // sub
    instr(6'b000000, 6'b001000, 0, "01",       3,  0,  0, 0, 1, 0, 0,  0,  0,  1,  0,   0); // jr
    instr(6'b101011, 6'b000000, 0, "0123",     0,  0,  1, 1, 0, 0, 0,  1,  0,  2,  0,   0); // sw
    instr(6'b101011, 6'b000000, 0, "01233",    0,  0,  1, 1, 0, 0, 0,  1,  0,  3,  3,   1); // sw, mem wait
    instr(6'b001111, 6'b000000, 0, "0124",     0,  3,  1, 0, 0, 0, 1,  0,  1,  1,  0,   0); // lui
    instr(6'b000000, 6'b000000, 0, "01",       0,  0,  0, 0, 1, 0, 0,  0,  0,  1,  0,   0); // nop
    chk("instret_12", instret, 12);

    // j is illegal on the base instance (halts) but retires on the extended one.
    opcode = 6'b000010; funct = 6'b0; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("illegal_pulse", illegal, 1);
    chk("illegal_no_pcwr", PCWr, 0);
    chk("ext_j_pcwr", x_PCWr, 1);
    chk("ext_j_npc", x_NPCOp, 2);
    chk("ext_j_legal", x_illegal, 0);
    @(posedge clk); #1;
    chk("halt_state", state, 5);
    chk("halted", halted, 1);
    chk("illegal_once", illegal, 0);

    ext_instr(6'b000000, 6'b100100, 4, 3'b100, 0); // and
    ext_instr(6'b000000, 6'b100101, 4, 3'b010, 0); // or
    ext_instr(6'b000000, 6'b101010, 4, 3'b101, 0); // slt
    ext_instr(6'b111111, 6'b000000, 2, 3'b000, 1); // illegal, retired as nop
    chk("halt_absorbing", state, 5);
    chk("halt_mem_req", mem_req, 0);
    chk("instret_frozen", instret, 12);
    chk("ext_instret", x_instret, 17);

    do_reset();
    for (int i = 0; i < 17; i++)
      instr(6'b000000, 6'b000000, 0, "01", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    chk("instret_wrap", instret, 1);
    chk("ext_instret_17", x_instret, 17);

    // Reset in MEM of sw: strobes drop combinationally, nothing retires.
    opcode = 6'b101011; funct = 6'b0; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    chk("sw_mem_state", state, 3);
    chk("sw_mem_req", mem_req, 1);
    chk("sw_dmwr", DMWr, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_dmwr", DMWr, 0);
    chk("abort_pcwr", PCWr, 0);
    chk("abort_state", state, 0);
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1;
    chk("abort_instret", instret, 0);
    #1;
    chk("post_rst_mem_req", mem_req, 1);
    @(posedge clk); #1;
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
